// File: rtl/baud_tick_gen_if.sv
// Control/status bundle for baud_tick_gen: divisor load, phase sync, enable and tick outputs.
// Master drives the controls; the generator (slave) drives tick, bit_tick and div_q.
interface baud_tick_gen_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              en;
    logic              div_wr;
    logic [DIV_W-1:0]  div_val;
    logic [FRAC_W-1:0] frac_val;
    logic              sync;
    logic              tick;
    logic              bit_tick;
    logic [DIV_W-1:0]  div_q;

    modport master (
        output en, div_wr, div_val, frac_val, sync,
        input  tick, bit_tick, div_q
    );

    modport slave (
        input  en, div_wr, div_val, frac_val, sync,
        output tick, bit_tick, div_q
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Runtime-programmable oversample/bit tick generator for the UART blocks.
// Define BAUD_TICK_GEN_FRAC_EN to enable the fractional divisor accumulator.
module baud_tick_gen #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DIV_DEFAULT = 325,
    parameter int unsigned OVS         = 16,
    parameter int unsigned OVS_W       = 4,
    parameter int unsigned FRAC_W      = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    baud_tick_gen_if.slave bus
);

`ifdef BAUD_TICK_GEN_FRAC_EN
    // One extra bit so div_q+1 stays representable when the stretch flag is set.
    localparam int unsigned CNT_W = DIV_W + 1;
`else
    localparam int unsigned CNT_W = DIV_W;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d, term;
    logic [OVS_W-1:0] ovs_q, ovs_d;
    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    logic             tick_q, tick_d;
    logic             bit_tick_q, bit_tick_d;

`ifdef BAUD_TICK_GEN_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_q, stretch_d;
    logic [FRAC_W:0]   acc_sum;

    assign term    = {1'b0, div_reg_q} + CNT_W'(stretch_q);
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
`else
    logic unused_frac;

    assign term        = div_reg_q;
    assign unused_frac = ^bus.frac_val;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        ovs_d      = ovs_q;
        div_reg_d  = div_reg_q;
        tick_d     = 1'b0;
        bit_tick_d = 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
        frac_d     = frac_q;
        acc_d      = acc_q;
        stretch_d  = stretch_q;
`endif
        if (bus.div_wr) begin
            div_reg_d = bus.div_val;
            cnt_d     = '0;
            ovs_d     = '0;
`ifdef BAUD_TICK_GEN_FRAC_EN
            frac_d    = bus.frac_val;
            acc_d     = '0;
            stretch_d = 1'b0;
`endif
        end else if (bus.sync) begin
            cnt_d     = '0;
            ovs_d     = '0;
`ifdef BAUD_TICK_GEN_FRAC_EN
            acc_d     = '0;
            stretch_d = 1'b0;
`endif
        end else if (bus.en) begin
            if (cnt_q == term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (ovs_q == OVS_W'(OVS - 1)) begin
                    ovs_d      = '0;
                    bit_tick_d = 1'b1;
                end else begin
                    ovs_d = ovs_q + OVS_W'(1);
                end
`ifdef BAUD_TICK_GEN_FRAC_EN
                acc_d     = acc_sum[FRAC_W-1:0];
                stretch_d = acc_sum[FRAC_W];
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            ovs_q      <= '0;
            div_reg_q  <= DIV_W'(DIV_DEFAULT);
            tick_q     <= 1'b0;
            bit_tick_q <= 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
            frac_q     <= '0;
            acc_q      <= '0;
            stretch_q  <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            ovs_q      <= ovs_d;
            div_reg_q  <= div_reg_d;
            tick_q     <= tick_d;
            bit_tick_q <= bit_tick_d;
`ifdef BAUD_TICK_GEN_FRAC_EN
            frac_q     <= frac_d;
            acc_q      <= acc_d;
            stretch_q  <= stretch_d;
`endif
        end
    end

    assign bus.tick     = tick_q;
    assign bus.bit_tick = bit_tick_q;
    assign bus.div_q    = div_reg_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: divisor table plus directed corner sequences.
// Expected fractional periods depend on BAUD_TICK_GEN_FRAC_EN, matching the DUT build.
module tb_baud_tick_gen;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;

    typedef struct {
        int unsigned div_val;
        int unsigned frac_val;
        int unsigned period;
        int unsigned bit_clks;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   orphan_bits = 0;

    always #5 clk = ~clk;

    baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    baud_tick_gen #(
        .DIV_W      (DIV_W),
        .DIV_DEFAULT(325),
        .OVS        (16),
        .OVS_W      (4),
        .FRAC_W     (FRAC_W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.bit_tick && !bus.tick) orphan_bits++;
    endtask

    // Edges until tick is seen high; returns limit+1 on timeout.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick && n <= limit);
    endtask

    task automatic load(input int unsigned dv, input int unsigned fv);
        bus.div_val  = DIV_W'(dv);
        bus.frac_val = FRAC_W'(fv);
        bus.div_wr   = 1'b1;
        step();
        bus.div_wr   = 1'b0;
    endtask

    // 16 ticks from a freshly cleared phase: fixed period, bit_tick only on the 16th.
    task automatic check_ticks(input string tag, input int period);
        int n;
        int total;
        total = 0;
        for (int k = 1; k <= 16; k++) begin
            wait_tick(period + 5, n);
            total += n;
            chk({tag, "_period"}, 64'(n), 64'(period));
            chk({tag, "_bit"}, 64'(bus.bit_tick), (k == 16) ? 64'd1 : 64'd0);
        end
        chk({tag, "_bit_span"}, 64'(total), 64'(16 * period));
    endtask

    vec_t vecs[4];

    initial begin
        int n;
        int total;
        int tcount;
        int bcount;

        vecs[0] = '{div_val: 9, frac_val: 0, period: 10, bit_clks: 160};
        vecs[1] = '{div_val: 0, frac_val: 0, period: 1,  bit_clks: 16};
        vecs[2] = '{div_val: 3, frac_val: 0, period: 4,  bit_clks: 64};
        vecs[3] = '{div_val: 1, frac_val: 0, period: 2,  bit_clks: 32};

        bus.en       = 1'b1;
        bus.div_wr   = 1'b0;
        bus.sync     = 1'b0;
        bus.div_val  = '0;
        bus.frac_val = '0;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
        chk("rst_tick", 64'(bus.tick), 64'd0);
        chk("rst_bit", 64'(bus.bit_tick), 64'd0);
        chk("rst_div_q", 64'(bus.div_q), 64'd325);
        check_ticks("default", 326);

        // Divisor table.
        foreach (vecs[i]) begin
            load(vecs[i].div_val, vecs[i].frac_val);
            chk("tbl_load_tick", 64'(bus.tick), 64'd0);
            chk("tbl_div_q", 64'(bus.div_q), 64'(vecs[i].div_val));
            total = 0;
            for (int k = 1; k <= 16; k++) begin
                wait_tick(int'(vecs[i].period) + 5, n);
                total += n;
                chk("tbl_period", 64'(n), 64'(vecs[i].period));
            end
            chk("tbl_bit", 64'(bus.bit_tick), 64'd1);
            chk("tbl_bit_span", 64'(total), 64'(vecs[i].bit_clks));
        end

        // Enable gap of 7 clocks three clocks into a period.
        load(9, 0);
        repeat (3) step();
        bus.en = 1'b0;
        tcount = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (bus.tick) tcount++;
        end
        chk("gap_no_tick", 64'(tcount), 64'd0);
        bus.en = 1'b1;
        wait_tick(20, n);
        chk("gap_resume", 64'(n), 64'd7);

        // div_wr on the terminal edge after a few ticks.
        load(9, 0);
        repeat (5) wait_tick(15, n);
        repeat (9) step();
        bus.div_wr = 1'b1;
        step();
        bus.div_wr = 1'b0;
        chk("wr_term_tick", 64'(bus.tick), 64'd0);
        check_ticks("wr_term", 10);

        // sync on the terminal edge keeps the divisor.
        repeat (5) wait_tick(15, n);
        repeat (9) step();
        bus.div_val = 16'd4;
        bus.sync    = 1'b1;
        step();
        bus.sync    = 1'b0;
        chk("sync_term_tick", 64'(bus.tick), 64'd0);
        chk("sync_div_q", 64'(bus.div_q), 64'd9);
        check_ticks("sync_term", 10);

        // div_wr outranks sync.
        bus.div_val = 16'd5;
        bus.div_wr  = 1'b1;
        bus.sync    = 1'b1;
        step();
        bus.div_wr  = 1'b0;
        bus.sync    = 1'b0;
        chk("prio_div_q", 64'(bus.div_q), 64'd5);
        wait_tick(15, n);
        chk("prio_period", 64'(n), 64'd6);

        // div_q==0: continuous tick, bit_tick 1 in 16.
        load(0, 0);
        tcount = 0;
        bcount = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (bus.tick) tcount++;
            if (bus.bit_tick) bcount++;
        end
        chk("div0_ticks", 64'(tcount), 64'd32);
        chk("div0_bits", 64'(bcount), 64'd2);
        bus.en = 1'b0;
        step();
        chk("div0_en_off", 64'(bus.tick), 64'd0);
        bus.en = 1'b1;

        // Reset mid-period.
        load(9, 0);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_tick", 64'(bus.tick), 64'd0);
        chk("midrst_bit", 64'(bus.bit_tick), 64'd0);
        chk("midrst_div_q", 64'(bus.div_q), 64'd325);

        // Fractional divisor: after the first tick the periods settle into 10,11,10,11...
        load(9, 8);
        wait_tick(20, n);
        chk("frac_first", 64'(n), 64'd10);
        total = 0;
        for (int j = 1; j <= 32; j++) begin
            wait_tick(20, n);
            total += n;
`ifdef BAUD_TICK_GEN_FRAC_EN
            chk("frac_period", 64'(n), (j % 2 == 1) ? 64'd10 : 64'd11);
`else
            chk("frac_period", 64'(n), 64'd10);
`endif
        end
`ifdef BAUD_TICK_GEN_FRAC_EN
        chk("frac_span", 64'(total), 64'd336);
`else
        chk("frac_span", 64'(total), 64'd320);
`endif

        // All-ones divisor: counter must reach the top value without wrapping.
        load(32'hFFFF, 0);
        wait_tick(70000, n);
        chk("max_div_period", 64'(n), 64'd65536);

        chk("bit_without_tick", 64'(orphan_bits), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised, runtime-programmable baud-rate tick generator.
- Successor to the fixed divide-by-326 generator, feeding the UART RX/TX blocks.
- Produces a one-clock oversample tick (`tick`) and a one-clock bit tick (`bit_tick`, every OVS oversample ticks).
- Divisor is loadable at run time; phase can be resynchronised for RX start-bit alignment.

Parameters:
- DIV_W, 16, width of the divisor register and of the clock counter.
- DIV_DEFAULT, 325, divisor loaded at reset. Tick period is DIV_DEFAULT+1 clocks.
- OVS, 16, oversample ticks per bit tick (>=1).
- OVS_W, 4, width of the oversample counter; must satisfy 2^OVS_W >= OVS.
- FRAC_W, 4, width of the fractional divisor (used only with FRAC_EN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes all counters.
- div_wr  in  1  one-cycle strobe that loads div_val (and frac_val).
- div_val  in  DIV_W  new integer divisor; tick period = div_val+1 clocks.
- frac_val  in  FRAC_W  new fractional divisor (ignored without FRAC_EN).
- sync  in  1  phase restart strobe; clears counters, divisor kept.
- tick  out  1  oversample tick, high for exactly one clock.
- bit_tick  out  1  bit tick, high for one clock, coincident with every OVS-th tick.
- div_q  out  DIV_W  currently active divisor (readback).

Behaviour:
- Reset is synchronous and active-high. At reset: cnt=0, ovs_cnt=0, div_q=DIV_DEFAULT, frac_q=0, acc=0, tick=0, bit_tick=0.
- Priority, highest first: reset > div_wr > sync > en-gated counting.
- Counting (en=1):
  - If cnt==term, then cnt<=0 and a tick event occurs; otherwise cnt<=cnt+1.
  - term = div_q, or div_q+1 when the FRAC_EN stretch flag is set.
- Outputs are registered:
  - tick goes high for the cycle after the edge where the event is detected. Otherwise tick is 0.
  - After reset with en held high, the first tick is high after the (div_q+1)th rising edge. Subsequent ticks follow every div_q+1 clocks.
- Oversample counter:
  - On a tick event, if ovs_cnt==OVS-1, then ovs_cnt<=0 and bit_tick is registered high together with tick. Otherwise ovs_cnt<=ovs_cnt+1.
  - bit_tick is never high without tick.
- en=0:
  - cnt, ovs_cnt and acc hold; tick=bit_tick=0 the following cycle.
  - Counting resumes from the held values; no tick is lost or duplicated.
- div_wr:
  - Loads div_q<=div_val and frac_q<=frac_val.
  - Clears cnt, ovs_cnt, acc and the stretch flag.
  - Forces tick=bit_tick=0 next cycle, even if cnt==term that edge. Applies regardless of en.
- sync:
  - Clears cnt, ovs_cnt, acc and the stretch flag; div_q and frac_q are unchanged.
  - Suppresses the tick that edge. Applies regardless of en.
- div_q==0: a tick event occurs on every enabled edge (tick held high continuously while en=1). bit_tick fires every OVS clocks.
- div_q at all-ones: cnt reaches 2^DIV_W-1 without overflow.
- Stretch: if the stretch flag would make term exceed the DIV_W range, the counter widens internally by one bit. No wrap is permitted.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BAUD_TICK_GEN_FRAC_EN.
- Defined:
  - On each tick event, {carry, acc} <= acc + frac_q (FRAC_W-bit accumulator).
  - The stretch flag <= carry, so the next period is div_q+2 clocks instead of div_q+1.
  - Mean period = div_q+1+frac_q/2^FRAC_W.
- Undefined:
  - frac_val is ignored; acc and the stretch flag do not exist (term=div_q always).
  - Period is exactly div_q+1.
- The port list is identical in both builds.

Test Plan:
- Reset then en=1 with defaults -> first tick after 326 clocks, ticks every 326 clocks. bit_tick coincides with the 16th tick, then every 5216 clocks; div_q=325.
- div_wr with div_val=9, en=1 -> no tick the load cycle, tick every 10 clocks, bit_tick every 160 clocks. Then en=0 for 7 clocks mid-period -> no ticks; after resume the tick lands exactly 7 clocks later than otherwise.
- div_val=9 loaded, with div_wr asserted on the edge where cnt==9 -> that tick is suppressed, next tick 10 clocks later, ovs_cnt restarts at 0. Same check with sync instead of div_wr -> div_q stays 9.
- div_val=0 -> tick high every enabled clock, bit_tick high 1 in 16 clocks. Also verify reset asserted mid-period -> outputs 0 next cycle and div_q returns to 325.
- With BAUD_TICK_GEN_FRAC_EN, div_val=9, frac_val=8 -> tick periods alternate 10,11,10,11; 32 ticks span 336 clocks.
- Without the macro, same stimulus -> all periods 10.
